// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and slot-priority encoding for the fetch stage and hazard units
package mips_pkg;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  typedef enum logic [2:0] {
    SLOT_RESET,
    SLOT_REDIRECT,
    SLOT_BUBBLE,
    SLOT_STALL,
    SLOT_ADVANCE
  } slot_e;
  function automatic slot_e slot_sel(input logic rst, input logic redirect, input logic [1:0] bubble, input logic stall);
    return rst ? SLOT_RESET : redirect ? SLOT_REDIRECT : |bubble ? SLOT_BUBBLE : stall ? SLOT_STALL : SLOT_ADVANCE;
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush-to-NOP, load and hold
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc4_d,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);
  // flush wins over load; neither means hold
  always_ff @(posedge clk)
    if (rst || flush) begin
      instr <= NOP;
      pc4 <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      pc4 <= pc4_d;
      valid <= 1'b1;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, redirect/bubble/stall priority, IF/ID register and squash counter
module fetch_stage #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       bubble,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             stall,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic             misalign,
  output logic [CNT_W-1:0] squash_cnt
);
  import mips_pkg::*;
  logic [31:0] pc, pc4;
  slot_e slot;
  logic squash, hold;
  assign pc4 = pc + PC_STEP;
  assign imem_addr = pc;
  assign slot = slot_sel(rst, redirect, bubble, stall);
  assign squash = slot == SLOT_REDIRECT || slot == SLOT_BUBBLE;
  assign hold = slot == SLOT_STALL || (slot == SLOT_BUBBLE && stall);
  // PC update, misalign pulse and saturating squash count
  always_ff @(posedge clk)
    if (slot == SLOT_RESET) begin
      pc <= RESET_PC;
      misalign <= 1'b0;
      squash_cnt <= '0;
    end else begin
      pc <= slot == SLOT_REDIRECT ? {redirect_pc[31:2], 2'b00} : hold ? pc : pc4;
      misalign <= slot == SLOT_REDIRECT && |redirect_pc[1:0];
      if (squash && !(&squash_cnt)) squash_cnt <= squash_cnt + CNT_W'(1);
    end
  if_id_reg u_if_id (
    .clk(clk),
    .rst(rst),
    .load(slot == SLOT_ADVANCE),
    .flush(squash),
    .instr_d(imem_rdata),
    .pc4_d(pc4),
    .instr(id_instr),
    .pc4(id_pc4),
    .valid(id_valid)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed checks of fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst, redirect, stall;
  logic [1:0] bubble;
  logic [31:0] redirect_pc;
  logic [31:0] imem_rdata, imem_addr, id_instr, id_pc4;
  logic id_valid, misalign;
  logic [15:0] squash_cnt;
  logic [31:0] imem_rdata2, imem_addr2, id_instr2, id_pc42;
  logic id_valid2, misalign2;
  logic [2:0] squash_cnt2;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  assign imem_rdata = {imem_addr[15:0], 16'hC0DE};
  assign imem_rdata2 = {imem_addr2[15:0], 16'hC0DE};
  fetch_stage dut (
    .clk(clk), .rst(rst), .bubble(bubble), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .imem_rdata(imem_rdata), .imem_addr(imem_addr), .id_instr(id_instr),
    .id_pc4(id_pc4), .id_valid(id_valid), .misalign(misalign), .squash_cnt(squash_cnt)
  );
  fetch_stage #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .bubble(bubble), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .imem_rdata(imem_rdata2), .imem_addr(imem_addr2), .id_instr(id_instr2),
    .id_pc4(id_pc42), .id_valid(id_valid2), .misalign(misalign2), .squash_cnt(squash_cnt2)
  );
  typedef struct {
    logic rst;
    logic red;
    logic [31:0] rpc;
    logic [1:0] bub;
    logic stl;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic valid;
    logic mis;
    logic [15:0] cnt;
  } vec_t;
  vec_t v[$];
  task automatic add(input logic r, input logic rd, input logic [31:0] rp, input logic [1:0] b, input logic s,
                     input logic [31:0] a, input logic [31:0] i, input logic [31:0] p, input logic vl,
                     input logic m, input logic [15:0] c);
    vec_t t;
    t = '{r, rd, rp, b, s, a, i, p, vl, m, c};
    v.push_back(t);
  endtask
  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic rd, input logic [31:0] rp, input logic [1:0] b, input logic s);
    @(negedge clk);
    rst = r;
    redirect = rd;
    redirect_pc = rp;
    bubble = b;
    stall = s;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] sat;
    int n;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    bubble = '0;
    stall = 1'b0;
    //   rst red rpc           bub stl  addr          instr         pc4           v  mis cnt
    add(1, 0, 32'h0,        0, 0, 32'h3000,     32'h0,         32'h0,        0, 0, 0);
    add(1, 0, 32'h0,        0, 0, 32'h3000,     32'h0,         32'h0,        0, 0, 0);
    add(0, 0, 32'h0,        0, 0, 32'h3004,     32'h3000C0DE,  32'h3004,     1, 0, 0);
    add(0, 0, 32'h0,        0, 0, 32'h3008,     32'h3004C0DE,  32'h3008,     1, 0, 0);
    add(0, 0, 32'h0,        0, 0, 32'h300C,     32'h3008C0DE,  32'h300C,     1, 0, 0);
    add(0, 0, 32'h0,        0, 0, 32'h3010,     32'h300CC0DE,  32'h3010,     1, 0, 0);
    add(0, 1, 32'h3040,     0, 0, 32'h3040,     32'h0,         32'h0,        0, 0, 1);
    add(0, 0, 32'h0,        3, 0, 32'h3044,     32'h0,         32'h0,        0, 0, 2);
    add(0, 0, 32'h0,        2, 0, 32'h3048,     32'h0,         32'h0,        0, 0, 3);
    add(0, 0, 32'h0,        1, 0, 32'h304C,     32'h0,         32'h0,        0, 0, 4);
    add(0, 0, 32'h0,        0, 0, 32'h3050,     32'h304CC0DE,  32'h3050,     1, 0, 4);
    add(0, 0, 32'h0,        2, 1, 32'h3050,     32'h0,         32'h0,        0, 0, 5);
    add(0, 0, 32'h0,        0, 0, 32'h3054,     32'h3050C0DE,  32'h3054,     1, 0, 5);
    add(0, 0, 32'h0,        0, 1, 32'h3054,     32'h3050C0DE,  32'h3054,     1, 0, 5);
    add(0, 1, 32'h3042,     0, 1, 32'h3040,     32'h0,         32'h0,        0, 1, 6);
    add(0, 0, 32'h0,        0, 0, 32'h3044,     32'h3040C0DE,  32'h3044,     1, 0, 6);
    add(0, 1, 32'h3100,     1, 0, 32'h3100,     32'h0,         32'h0,        0, 0, 7);
    add(0, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 32'h0,         32'h0,        0, 0, 8);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'hFFFCC0DE,  32'h0,        1, 0, 8);
    add(0, 0, 32'h0,        0, 0, 32'h4,        32'h0000C0DE,  32'h4,        1, 0, 8);
    add(1, 0, 32'h0,        2, 0, 32'h3000,     32'h0,         32'h0,        0, 0, 0);
    add(0, 0, 32'h0,        1, 0, 32'h3004,     32'h0,         32'h0,        0, 0, 1);
    add(0, 0, 32'h0,        0, 0, 32'h3008,     32'h3004C0DE,  32'h3008,     1, 0, 1);
    add(0, 1, 32'h3203,     0, 0, 32'h3200,     32'h0,         32'h0,        0, 1, 2);
    add(1, 1, 32'h3042,     0, 0, 32'h3000,     32'h0,         32'h0,        0, 0, 0);
    for (int k = 0; k < v.size(); k++) begin
      drive(v[k].rst, v[k].red, v[k].rpc, v[k].bub, v[k].stl);
      sat = v[k].cnt > 16'd7 ? 16'd7 : v[k].cnt;
      chk("imem_addr", k, imem_addr, v[k].addr);
      chk("id_instr", k, id_instr, v[k].instr);
      chk("id_valid", k, {31'b0, id_valid}, {31'b0, v[k].valid});
      chk("misalign", k, {31'b0, misalign}, {31'b0, v[k].mis});
      chk("squash_cnt", k, {16'b0, squash_cnt}, {16'b0, v[k].cnt});
      chk("squash_cnt_sat3", k, {29'b0, squash_cnt2}, {16'b0, sat});
      if (v[k].valid) chk("id_pc4", k, id_pc4, v[k].pc4);
    end
    // after reset release, the first valid slot must arrive within a bounded number of cycles
    drive(0, 0, 32'h0, 0, 0);
    n = 1;
    while (!id_valid && n < 5) begin
      drive(0, 0, 32'h0, 0, 0);
      n++;
    end
    chk("first_valid_latency", 0, n, 1);
    chk("first_valid_pc4", 0, id_pc4, 32'h3004);
    // misalign pulse lasts exactly one cycle across a following stall
    drive(0, 1, 32'h3001, 0, 0);
    chk("mis_pulse_on", 0, {31'b0, misalign}, 32'h1);
    drive(0, 0, 32'h0, 0, 1);
    chk("mis_pulse_off", 0, {31'b0, misalign}, 32'h0);
    chk("mis_stall_addr", 0, imem_addr, 32'h3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core. It sits directly downstream of the control-hazard unit, consuming its 2-bit `bubble` countdown to squash wrong-path instructions into NOPs. It also owns the PC: it accepts taken branch/jump redirects from the branch-resolution logic and holds on load-use stalls. It drives the instruction-memory address and presents the fetched instruction, PC+4 and a valid bit to the decode stage.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset
- `CNT_W`, 16, width of the squash performance counter
- `clk` input 1: single clock, all state updates on rising edge
- `rst` input 1: reset, synchronous and active-high
- `bubble` input 2: remaining-bubble count from the control-hazard unit; nonzero means the slot now being latched is wrong-path
- `redirect` input 1: taken branch/jump/jal/jalr this cycle
- `redirect_pc` input 32: target address, valid when `redirect`=1
- `stall` input 1: load-use hold request from the data-hazard unit
- `imem_rdata` input 32: instruction at `imem_addr` (combinational memory)
- `imem_addr` output 32: current PC
- `id_instr` output 32: IF/ID instruction
- `id_pc4` output 32: IF/ID PC+4 (link value for jal/jalr)
- `id_valid` output 1: IF/ID holds a real instruction
- `misalign` output 1: one-cycle pulse, redirect target had nonzero low bits
- `squash_cnt` output CNT_W: saturating count of squashed slots

## Operation
- Per-edge priority, highest first: `rst` > `redirect` > `bubble`≠0 > `stall` > normal advance.
- rst: PC←RESET_PC; id_instr←NOP (32'h0); id_pc4←0; id_valid←0; misalign←0; squash_cnt←0.
- redirect: PC←{redirect_pc[31:2],2'b00}; IF/ID←NOP, id_valid←0; squash_cnt increments; misalign←(redirect_pc[1:0]≠0). Stall ignored.
- bubble≠0 (no redirect): IF/ID←NOP, id_valid←0; squash_cnt increments; PC←PC+4 unless `stall`=1, then PC holds.
- stall only: PC and all IF/ID fields hold.
- normal: PC←PC+4; id_instr←imem_rdata; id_pc4←PC+4; id_valid←1.
- misalign is cleared on every edge where it is not re-asserted.
- PC arithmetic is modulo 2^32: PC=32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- squash_cnt saturates at all-ones and does not wrap.
- `bubble` is trusted as given. Values 1–3 are treated identically, and the stage keeps no copy of the countdown.

## Timing
- Combinational path: `imem_addr` = PC register.
- Fetch latency is one cycle: the instruction at PC appears on id_instr one edge after PC is presented.
- Redirect latency is one cycle: target on `imem_addr` the edge after `redirect`=1, and its instruction is in IF/ID one edge later (if not squashed).
- Reset mid-redirect or mid-bubble: the reset state wins on that edge. Squash resumes only if `bubble` is still nonzero afterwards.
- Simultaneous `stall` with `bubble`≠0 inserts a NOP but holds PC, so the held instruction is refetched.

## Structure
- Shared package `mips_pkg`: `NOP` (32'h0), `PC_STEP` (4), `RESET_PC` default, and the slot-priority encoding used by both this stage and the hazard units.
- One sub-module, `if_id_reg`, holds instr/pc4/valid with load, flush and hold controls. The PC, priority mux, misalign and counter live in `fetch_stage`.

## Test plan
- Reset: hold rst 2 cycles, release → imem_addr=32'h3000, id_valid=0, squash_cnt=0. The next edge latches the word at 0x3000, with id_pc4=32'h3004 and id_valid=1.
- Straight-line: 4 edges of no control → imem_addr steps 3000/3004/3008/300C, and id_instr tracks imem_rdata with one-cycle lag.
- Redirect + bubble: redirect=1, redirect_pc=32'h3040 with bubble=0, then bubble=3,2,1 → imem_addr=3040 next edge. Four NOP slots follow with id_valid=0, and squash_cnt=4.
- Stall vs bubble: stall=1 with bubble=2 at PC=3010 → PC stays 3010 and IF/ID becomes NOP. Stall=1 with bubble=0 → PC and IF/ID unchanged.
- Misaligned target: redirect_pc=32'h3042 → imem_addr=32'h3040, misalign high exactly one cycle.
- Wrap/saturation: force PC to FFFF_FFFC → next imem_addr=0. Preload squash_cnt=16'hFFFF and apply a redirect → the counter stays FFFF.
